// File: rtl/fifo_rd_stream.sv
// Purpose : turns the FIFO pop interface (rd_en/empty, data one cycle after rd_en) into a valid/ready stream.
// Latency : o_rd_en in cycle N gives o_valid/o_data in cycle N+2 when the buffer starts empty; one beat per cycle sustained.
// Backpres: 2-entry skid buffer; pops stop once buffered + in-flight words would exceed 2, so the FIFO is never over-read.
//
// Ports:
//   i_rclk, i_rrst_n       read-domain clock, asynchronous active-low reset
//   o_rd_en                FIFO pop request (combinational, gated off during reset)
//   i_empty, i_rdata       FIFO empty flag and read data (data valid the cycle after o_rd_en)
//   o_valid, o_data        stream beat and data, taken from the head of the buffer
//   i_ready                sink accepts the beat when o_valid & i_ready
//   o_beat_cnt             16-bit accepted-beat counter, present only when FIFO_RDSTREAM_CNT_EN is defined
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_rclk,
    input  logic                  i_rrst_n,
    output logic                  o_rd_en,
    input  logic                  i_empty,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_ready
`ifdef FIFO_RDSTREAM_CNT_EN
    ,
    output logic [15:0]           o_beat_cnt
`endif
);

    logic [1:0]            occ_q;
    logic [1:0]            occ_d;
    logic                  inflight_q;
    logic                  head_q;
    logic                  head_d;
    logic                  tail_q;
    logic                  tail_d;
    logic [DATA_WIDTH-1:0] slot_q [2];
    logic                  pop;
    logic [2:0]            occ_sum;

    assign pop = o_valid & i_ready;

    // Words that will still be held after this edge. Computed one bit wider so the
    // comparison below cannot alias; pop implies occ_q != 0, so no underflow.
    assign occ_sum = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

    // Only pop when the word can land in a free slot next cycle; this is what makes
    // overflow impossible without any explicit full check on the write side.
    assign o_rd_en = i_rrst_n & ~i_empty & (occ_sum < 3'd2);

    always_comb begin
        occ_d  = occ_sum[1:0];
        head_d = pop ? ~head_q : head_q;
        tail_d = inflight_q ? ~tail_q : tail_q;
    end

    always_ff @(posedge i_rclk or negedge i_rrst_n) begin
        if (!i_rrst_n) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            slot_q[0]  <= '0;
            slot_q[1]  <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= o_rd_en;
            head_q     <= head_d;
            tail_q     <= tail_d;
            // Returning FIFO data always goes to the tail; a simultaneous pop frees the
            // head slot, which is never the tail slot when occupancy is non-zero.
            if (inflight_q) begin
                slot_q[tail_q] <= i_rdata;
            end
        end
    end

    assign o_valid = (occ_q != 2'd0);
    assign o_data  = slot_q[head_q];

`ifdef FIFO_RDSTREAM_CNT_EN
    logic [15:0] beat_cnt_q;
    logic [15:0] beat_cnt_d;

    // Free-running, wraps naturally at 16 bits.
    assign beat_cnt_d = pop ? beat_cnt_q + 16'd1 : beat_cnt_q;

    always_ff @(posedge i_rclk or negedge i_rrst_n) begin
        if (!i_rrst_n) begin
            beat_cnt_q <= 16'd0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign o_beat_cnt = beat_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Purpose : directed + random check of fifo_rd_stream against a behavioural FIFO and a data scoreboard.
// Latency : checks the two-cycle rd_en -> valid latency and back-to-back streaming.
// Backpres: drives stalls, random ready and random empty; checks at most two words are ever outstanding.
module tb_fifo_rd_stream;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rd_en;
    logic       empty;
    logic [7:0] rdata = 8'h00;
    logic       valid;
    logic [7:0] data;
    logic       ready = 1'b0;
`ifdef FIFO_RDSTREAM_CNT_EN
    logic [15:0] beat_cnt;
`endif

    fifo_rd_stream #(.DATA_WIDTH(8)) dut (
        .i_rclk   (clk),
        .i_rrst_n (rst_n),
        .o_rd_en  (rd_en),
        .i_empty  (empty),
        .i_rdata  (rdata),
        .o_valid  (valid),
        .o_data   (data),
        .i_ready  (ready)
`ifdef FIFO_RDSTREAM_CNT_EN
        ,
        .o_beat_cnt (beat_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: storage written by the stimulus, popped on rd_en with data
    // returned the following cycle.
    logic [7:0] mem [0:2047];
    int         rd_ptr = 0;
    int         wr_ptr = 0;
    int         drawn = 0;
    bit         force_empty = 1'b0;

    assign empty = (rd_ptr == wr_ptr) || force_empty;

    always @(posedge clk) begin
        if (rd_en) begin
            rdata  <= mem[rd_ptr[10:0]];
            rd_ptr <= rd_ptr + 1;
            drawn  <= drawn + 1;
        end
    end

    int          n_assert = 0;
    int          n_fail = 0;
    int          pops_done = 0;
    logic [15:0] cnt_model = 16'd0;
    logic [7:0]  sb [$];
    bit          popped_now = 1'b0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr[10:0]] = d;
        wr_ptr = wr_ptr + 1;
        sb.push_back(d);
    endtask

    // One clock: sample at the falling edge, scoreboard any accepted beat, then
    // return just after the rising edge so the caller can drive the next inputs.
    task automatic cyc();
        logic [7:0] e;
        @(negedge clk);
        popped_now = 1'b0;
        if (rst_n) begin
            chk("outstanding_le2", {31'd0, ((drawn - pops_done) <= 2)}, 32'd1);
            if (rd_en) chk("rden_while_empty", {31'd0, empty}, 32'd0);
            if (prev_stall) chk("stall_data_hold", {24'd0, data}, {24'd0, prev_data});
`ifdef FIFO_RDSTREAM_CNT_EN
            chk("beat_cnt", {16'd0, beat_cnt}, {16'd0, cnt_model});
`endif
            if (valid && ready) begin
                chk("sb_nonempty", {31'd0, (sb.size() != 0)}, 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("stream_data", {24'd0, data}, {24'd0, e});
                end
                popped_now = 1'b1;
                pops_done  = pops_done + 1;
                cnt_model  = cnt_model + 16'd1;
            end
            prev_stall = valid && !ready;
            prev_data  = data;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int base_drawn;
        int first;
        int last;
        int npop;
        int guard;

        // 1. Reset holds everything quiet even with the FIFO non-empty.
        push(8'hA5);
        ready = 1'b1;
        #2;
        for (int i = 0; i < 3; i++) begin
            chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
            chk("rst_valid", {31'd0, valid}, 32'd0);
            chk("rst_data", {24'd0, data}, 32'd0);
            cyc();
        end

        // 2. Single word: rd_en for one cycle, beat two cycles later for one cycle.
        rst_n = 1'b1;
        base  = pops_done;
        #1;
        chk("t2_rd_en_first", {31'd0, rd_en}, 32'd1);
        cyc();
        chk("t2_rd_en_drop", {31'd0, rd_en}, 32'd0);
        chk("t2_valid_n1", {31'd0, valid}, 32'd0);
        cyc();
        chk("t2_valid_n2", {31'd0, valid}, 32'd1);
        chk("t2_data_n2", {24'd0, data}, 32'h0000_00A5);
        cyc();
        chk("t2_valid_after", {31'd0, valid}, 32'd0);
        chk("t2_pops", pops_done - base, 32'd1);
`ifdef FIFO_RDSTREAM_CNT_EN
        chk("t2_beat_cnt", {16'd0, beat_cnt}, 32'd1);
`endif

        // 3. Streaming 16 words with the sink always ready: no gaps.
        base  = pops_done;
        first = -1;
        last  = -1;
        npop  = 0;
        for (int i = 0; i < 16; i++) push(8'(i));
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (popped_now) begin
                if (first < 0) first = i;
                last = i;
                npop++;
            end
        end
        chk("t3_count", npop, 32'd16);
        chk("t3_span", last - first, 32'd15);

        // 4. Back-pressure: exactly two words drawn while stalled, then all eight in order.
        ready      = 1'b0;
        base_drawn = drawn;
        for (int i = 0; i < 8; i++) push(8'(i));
        for (int i = 0; i < 10; i++) cyc();
        chk("t4_stall_draws", drawn - base_drawn, 32'd2);
        chk("t4_stall_valid", {31'd0, valid}, 32'd1);
        chk("t4_stall_data", {24'd0, data}, 32'd0);
        ready = 1'b1;
        base  = pops_done;
        for (int i = 0; i < 20; i++) cyc();
        chk("t4_delivered", pops_done - base, 32'd8);
        chk("t4_sb_empty", 32'(sb.size()), 32'd0);

        // 5. Reset with two words buffered: valid drops at once, nothing stale afterwards.
        ready      = 1'b0;
        base_drawn = drawn;
        for (int i = 0; i < 4; i++) push(8'h30 + 8'(i));
        for (int i = 0; i < 4; i++) cyc();
        chk("t5_buffered_valid", {31'd0, valid}, 32'd1);
        chk("t5_buffered_draws", drawn - base_drawn, 32'd2);
        rst_n = 1'b0;
        #1;
        chk("t5_async_valid", {31'd0, valid}, 32'd0);
        chk("t5_async_data", {24'd0, data}, 32'd0);
        chk("t5_async_rd_en", {31'd0, rd_en}, 32'd0);
        wr_ptr     = rd_ptr;
        sb.delete();
        pops_done  = drawn;
        cnt_model  = 16'd0;
        prev_stall = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t5_no_stale_valid", {31'd0, valid}, 32'd0);
        end

        // 6. Random ready and random empty, 1000 words.
        base = pops_done;
        for (int i = 0; i < 1000; i++) push(8'($urandom_range(0, 255)));
        guard = 0;
        while (sb.size() != 0 && guard < 8000) begin
            ready       = 1'($urandom_range(0, 1));
            force_empty = ($urandom_range(0, 3) == 0);
            cyc();
            guard++;
        end
        force_empty = 1'b0;
        chk("t6_sb_drained", 32'(sb.size()), 32'd0);
        chk("t6_delivered", pops_done - base, 32'd1000);
        ready = 1'b0;
        cyc();
        chk("t6_outstanding_zero", drawn - pops_done, 32'd0);
`ifdef FIFO_RDSTREAM_CNT_EN
        chk("t6_beat_cnt", {16'd0, beat_cnt}, 32'd1000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
